// File: rtl/axi_rtio_write_slave.sv
// AXI4 write-only slave for the RTIO command window: data-window beats become a 128-bit
// command stream, control-window writes raise a one-cycle restart pulse.
module axi_rtio_write_slave #(
    parameter int unsigned            ADDR_WIDTH  = 12,
    parameter logic [ADDR_WIDTH-1:0] DATA_OFFSET = 'h000,
    parameter logic [ADDR_WIDTH-1:0] CTRL_OFFSET = 'h004
) (
    input  logic                  s_axi_aclk,
    input  logic                  s_axi_areset,

    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic [1:0]            s_axi_awburst,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,

    input  logic [127:0]          s_axi_wdata,
    input  logic [15:0]           s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,

    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,

    output logic [127:0]          m_cmd_tdata,
    output logic                  m_cmd_tvalid,
    input  logic                  m_cmd_tready,

    output logic                  restart_pulse,
    output logic [15:0]           drop_count
);

    typedef enum logic [1:0] {StIdle, StData, StResp} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]              beats_q, beats_d;
    logic                    err_q, err_d;
    logic [127:0]            tdata_q, tdata_d;
    logic                    tvalid_q, tvalid_d;
    logic                    restart_q, restart_d;
    logic [15:0]             drop_q, drop_d;

    logic win_data;
    logic win_ctrl;
    logic last_beat;

    // Address is never incremented, so FIXED and INCR behave identically.
    logic unused_awburst;
    assign unused_awburst = ^s_axi_awburst;

    assign win_data  = (addr_q == DATA_OFFSET);
    assign win_ctrl  = (addr_q == CTRL_OFFSET);
    assign last_beat = (beats_q == 8'd0);

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        beats_d       = beats_q;
        err_d         = err_q;
        tdata_d       = tdata_q;
        tvalid_d      = tvalid_q;
        restart_d     = 1'b0;
        drop_d        = drop_q;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;

        if (tvalid_q && m_cmd_tready) begin
            tvalid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                s_axi_awready = 1'b1;
                if (s_axi_awvalid) begin
                    addr_d  = s_axi_awaddr;
                    beats_d = s_axi_awlen;
                    err_d   = 1'b0;
                    state_d = StData;
                end
            end
            StData: begin
                // Only the data window is throttled by the command stream.
                s_axi_wready = win_data ? (!tvalid_q || m_cmd_tready) : 1'b1;
                if (s_axi_wvalid && s_axi_wready) begin
                    if (s_axi_wlast != last_beat) begin
                        err_d = 1'b1;
                    end
                    if (win_data) begin
                        if (&s_axi_wstrb) begin
                            tdata_d  = s_axi_wdata;
                            tvalid_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                            if (drop_q != 16'hFFFF) begin
                                drop_d = drop_q + 16'd1;
                            end
                        end
                    end else if (win_ctrl) begin
                        restart_d = s_axi_wstrb[0] & s_axi_wdata[0];
                    end else begin
                        err_d = 1'b1;
                    end
                    if (last_beat) begin
                        state_d = StResp;
                    end else begin
                        beats_d = beats_q - 8'd1;
                    end
                end
            end
            StResp: begin
                s_axi_bvalid = 1'b1;
                if (s_axi_bready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            beats_q   <= '0;
            err_q     <= 1'b0;
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
            restart_q <= 1'b0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            beats_q   <= beats_d;
            err_q     <= err_d;
            tdata_q   <= tdata_d;
            tvalid_q  <= tvalid_d;
            restart_q <= restart_d;
            drop_q    <= drop_d;
        end
    end

    assign s_axi_bresp   = (state_q == StResp && err_q) ? 2'b10 : 2'b00;
    assign m_cmd_tdata   = tdata_q;
    assign m_cmd_tvalid  = tvalid_q;
    assign restart_pulse = restart_q;
    assign drop_count    = drop_q;

endmodule

// File: tb/tb_axi_rtio_write_slave.sv
// Directed bench for axi_rtio_write_slave: AXI write sequences with a command-stream
// scoreboard and a stall-stability monitor folded into the cycle-advance task.
module tb_axi_rtio_write_slave;

    logic         clk = 1'b0;
    logic         areset;
    logic [11:0]  awaddr;
    logic [7:0]   awlen;
    logic [1:0]   awburst;
    logic         awvalid, awready;
    logic [127:0] wdata;
    logic [15:0]  wstrb;
    logic         wlast, wvalid, wready;
    logic [1:0]   bresp;
    logic         bvalid, bready;
    logic [127:0] tdata;
    logic         tvalid, tready;
    logic         restart;
    logic [15:0]  drops;

    always #5 clk = ~clk;

    axi_rtio_write_slave dut (
        .s_axi_aclk    (clk),
        .s_axi_areset  (areset),
        .s_axi_awaddr  (awaddr),
        .s_axi_awlen   (awlen),
        .s_axi_awburst (awburst),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_wlast   (wlast),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_bresp   (bresp),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .m_cmd_tdata   (tdata),
        .m_cmd_tvalid  (tvalid),
        .m_cmd_tready  (tready),
        .restart_pulse (restart),
        .drop_count    (drops)
    );

    int errors = 0;
    int checks = 0;
    int restart_cnt = 0;
    logic toggle_en = 1'b0;
    logic [127:0] exp_q[$];
    logic [127:0] beat_data[4];
    logic [15:0]  beat_strb[4];
    logic         beat_last[4];
    logic [127:0] after_tdata;
    logic         after_tvalid;
    logic [1:0]   resp;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advances one clock; inputs and outputs are only touched at negedge+1.
    task automatic tick();
        logic         stall;
        logic [127:0] held;
        stall = tvalid && !tready && !areset;
        held  = tdata;
        if (!areset && tvalid === 1'b1 && tready) begin
            if (exp_q.size() == 0) begin
                check_eq("cmd_unexpected_beat", {127'd0, tvalid}, 128'd0);
            end else begin
                check_eq("cmd_word", tdata, exp_q.pop_front());
            end
        end
        @(negedge clk);
        if (toggle_en) tready = ~tready;
        #1;
        if (stall) begin
            check_eq("cmd_tvalid_held", {127'd0, tvalid}, 128'd1);
            check_eq("cmd_tdata_stable", tdata, held);
        end
        if (restart === 1'b1) restart_cnt++;
    endtask

    task automatic do_aw(input logic [11:0] addr, input logic [7:0] len);
        int n = 0;
        awaddr  = addr;
        awlen   = len;
        awburst = 2'b01;
        awvalid = 1'b1;
        while (!awready && n < 50) begin tick(); n++; end
        if (n >= 50) check_eq("aw_handshake_timeout", {127'd0, awready}, 128'd1);
        tick();
        awvalid = 1'b0;
    endtask

    task automatic do_w(input int nbeats);
        for (int i = 0; i < nbeats; i++) begin
            int n = 0;
            wdata  = beat_data[i];
            wstrb  = beat_strb[i];
            wlast  = beat_last[i];
            wvalid = 1'b1;
            while (!wready && n < 50) begin tick(); n++; end
            if (n >= 50) check_eq("w_handshake_timeout", {127'd0, wready}, 128'd1);
            tick();
            after_tdata  = tdata;
            after_tvalid = tvalid;
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
    endtask

    task automatic do_b(output logic [1:0] r);
        int n = 0;
        bready = 1'b1;
        while (!bvalid && n < 50) begin tick(); n++; end
        if (n >= 50) check_eq("b_handshake_timeout", {127'd0, bvalid}, 128'd1);
        r = bresp;
        tick();
        bready = 1'b0;
    endtask

    task automatic axi_write(input logic [11:0] addr, input int nbeats, output logic [1:0] r);
        do_aw(addr, 8'(nbeats - 1));
        do_w(nbeats);
        do_b(r);
    endtask

    task automatic set_beat(input int i, input logic [127:0] d, input logic [15:0] s,
                            input logic l);
        beat_data[i] = d;
        beat_strb[i] = s;
        beat_last[i] = l;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] d;
        areset = 1'b1; awaddr = '0; awlen = '0; awburst = 2'b01; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0; tready = 1'b1;
        repeat (3) tick();
        check_eq("rst_awready", {127'd0, awready}, 128'd1);
        check_eq("rst_wready", {127'd0, wready}, 128'd0);
        check_eq("rst_bvalid", {127'd0, bvalid}, 128'd0);
        check_eq("rst_bresp", {126'd0, bresp}, 128'd0);
        check_eq("rst_tvalid", {127'd0, tvalid}, 128'd0);
        check_eq("rst_tdata", tdata, 128'd0);
        check_eq("rst_restart", {127'd0, restart}, 128'd0);
        check_eq("rst_drops", {112'd0, drops}, 128'd0);
        areset = 1'b0;
        tick();

        // 1: single data write, one-cycle latency to m_cmd.
        d = 128'h0000_0000_0000_0001_FFFC_0000_0011_0210;
        set_beat(0, d, 16'hFFFF, 1'b1);
        exp_q.push_back(d);
        do_aw(12'h000, 8'd0);
        do_w(1);
        check_eq("t1_tvalid_after_w", {127'd0, after_tvalid}, 128'd1);
        check_eq("t1_tdata_after_w", after_tdata, d);
        do_b(resp);
        check_eq("t1_bresp", {126'd0, resp}, 128'd0);
        repeat (2) tick();
        check_eq("t1_drained", 128'(exp_q.size()), 128'd0);

        // 2: five writes with tready toggling.
        toggle_en = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            d = (128'(k * 32'h1000) << 64) | 128'(k);
            set_beat(0, d, 16'hFFFF, 1'b1);
            exp_q.push_back(d);
            axi_write(12'h000, 1, resp);
            check_eq("t2_bresp", {126'd0, resp}, 128'd0);
        end
        toggle_en = 1'b0;
        tready = 1'b1;
        repeat (3) tick();
        check_eq("t2_drained", 128'(exp_q.size()), 128'd0);

        // 3: control write raises restart for exactly one cycle.
        restart_cnt = 0;
        set_beat(0, 128'd1, 16'hFFFF, 1'b1);
        axi_write(12'h004, 1, resp);
        repeat (3) tick();
        check_eq("t3_bresp", {126'd0, resp}, 128'd0);
        check_eq("t3_restart_cycles", 128'(restart_cnt), 128'd1);
        check_eq("t3_tvalid", {127'd0, tvalid}, 128'd0);

        // 4: partial strobes are dropped and counted.
        set_beat(0, 128'hDEAD_BEEF, 16'h00FF, 1'b1);
        axi_write(12'h000, 1, resp);
        repeat (2) tick();
        check_eq("t4_bresp", {126'd0, resp}, 128'd2);
        check_eq("t4_drops", {112'd0, drops}, 128'd1);
        check_eq("t4_tvalid", {127'd0, tvalid}, 128'd0);

        // 5a: four-beat burst with early wlast on beat 2.
        for (int i = 0; i < 4; i++) begin
            d = 128'hA000 + 128'(i);
            set_beat(i, d, 16'hFFFF, (i == 1) || (i == 3));
            exp_q.push_back(d);
        end
        axi_write(12'h000, 4, resp);
        repeat (2) tick();
        check_eq("t5_burst_bresp", {126'd0, resp}, 128'd2);
        check_eq("t5_burst_drained", 128'(exp_q.size()), 128'd0);

        // 5b: unmapped offset consumes the beat and reports SLVERR.
        restart_cnt = 0;
        set_beat(0, 128'h1, 16'hFFFF, 1'b1);
        axi_write(12'h100, 1, resp);
        repeat (2) tick();
        check_eq("t5_unmapped_bresp", {126'd0, resp}, 128'd2);
        check_eq("t5_unmapped_restart", 128'(restart_cnt), 128'd0);
        check_eq("t5_unmapped_drops", {112'd0, drops}, 128'd1);
        check_eq("t5_unmapped_tvalid", {127'd0, tvalid}, 128'd0);

        // 6: reset with a stalled command word and a pending B response.
        tready = 1'b0;
        set_beat(0, 128'h5555, 16'hFFFF, 1'b1);
        do_aw(12'h000, 8'd0);
        do_w(1);
        check_eq("t6_pre_tvalid", {127'd0, tvalid}, 128'd1);
        check_eq("t6_pre_bvalid", {127'd0, bvalid}, 128'd1);
        areset = 1'b1;
        tick();
        check_eq("t6_rst_tvalid", {127'd0, tvalid}, 128'd0);
        check_eq("t6_rst_tdata", tdata, 128'd0);
        check_eq("t6_rst_bvalid", {127'd0, bvalid}, 128'd0);
        check_eq("t6_rst_awready", {127'd0, awready}, 128'd1);
        check_eq("t6_rst_wready", {127'd0, wready}, 128'd0);
        check_eq("t6_rst_drops", {112'd0, drops}, 128'd0);
        check_eq("t6_rst_restart", {127'd0, restart}, 128'd0);
        areset = 1'b0;
        tready = 1'b1;
        tick();
        d = 128'h1234_5678_9ABC_DEF0_0F1E_2D3C_4B5A_6978;
        set_beat(0, d, 16'hFFFF, 1'b1);
        exp_q.push_back(d);
        axi_write(12'h000, 1, resp);
        repeat (2) tick();
        check_eq("t6_post_bresp", {126'd0, resp}, 128'd0);
        check_eq("t6_post_drained", 128'(exp_q.size()), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
